// File: rtl/operand_entry.sv
// Operand entry: synchronizes switches and pushbuttons, debounces the buttons,
// and captures a pair of 5-bit operands (x then y) under a small FSM.
module operand_entry #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sw,
  input  logic       btn_load,
  input  logic       btn_clr,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic       ready,
  output logic       pair_stb,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    WAIT_X = 2'b00,
    WAIT_Y = 2'b01,
    READY  = 2'b10
  } state_t;

  localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

  logic [4:0]  sw_meta_r;
  logic [4:0]  sw_sync_r;
  logic [1:0]  btn_raw_s;
  logic [1:0]  btn_meta_r;
  logic [1:0]  btn_sync_r;
  logic [19:0] db_cnt_r [2];
  logic [1:0]  db_lvl_r;
  logic [1:0]  db_lvl_d_r;
  logic [1:0]  press_s;
  logic        load_p_s;
  logic        clr_p_s;
  state_t      state_r;
  logic [4:0]  x_r;
  logic [4:0]  y_r;
  logic        ready_r;
  logic        pair_stb_r;

  // Bit 0 is the load button, bit 1 the clear button.
  assign btn_raw_s = {btn_clr, btn_load};

  // Two-flop synchronizers for the switches and both buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_r  <= 5'd0;
      sw_sync_r  <= 5'd0;
      btn_meta_r <= 2'b00;
      btn_sync_r <= 2'b00;
    end else begin
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= btn_raw_s;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Per-button debouncer: the level flips only after DB_CYCLES disagreeing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r[0] <= 20'd0;
      db_cnt_r[1] <= 20'd0;
      db_lvl_r    <= 2'b00;
      db_lvl_d_r  <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_sync_r[i] == db_lvl_r[i]) begin
          db_cnt_r[i] <= 20'd0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_lvl_r[i] <= ~db_lvl_r[i];
          db_cnt_r[i] <= 20'd0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 20'd1;
        end
      end
      db_lvl_d_r <= db_lvl_r;
    end
  end

  // Rising edges of the debounced levels; both terms are registers, so the
  // pulse occupies exactly the cycle after the level rises.
  assign press_s  = db_lvl_r & ~db_lvl_d_r;
  assign load_p_s = press_s[0];
  assign clr_p_s  = press_s[1];

  // Operand capture FSM; clear wins over a simultaneous load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= WAIT_X;
      x_r        <= 5'd0;
      y_r        <= 5'd0;
      ready_r    <= 1'b0;
      pair_stb_r <= 1'b0;
    end else begin
      pair_stb_r <= 1'b0;
      if (clr_p_s) begin
        state_r <= WAIT_X;
        x_r     <= 5'd0;
        y_r     <= 5'd0;
        ready_r <= 1'b0;
      end else begin
        case (state_r)
          WAIT_X: begin
            if (load_p_s) begin
              x_r     <= sw_sync_r;
              state_r <= WAIT_Y;
            end
          end
          WAIT_Y: begin
            if (load_p_s) begin
              y_r        <= sw_sync_r;
              state_r    <= READY;
              ready_r    <= 1'b1;
              pair_stb_r <= 1'b1;
            end
          end
          READY: begin
            if (load_p_s) begin
              x_r     <= sw_sync_r;
              state_r <= WAIT_Y;
              ready_r <= 1'b0;
            end
          end
          default: begin
            state_r <= WAIT_X;
            ready_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x        = x_r;
  assign y        = y_r;
  assign ready    = ready_r;
  assign pair_stb = pair_stb_r;
  assign state    = state_r;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with DB_CYCLES=4.
`timescale 1ns/100ps
module tb_operand_entry;

  logic       clk;
  logic       rst_n;
  logic [4:0] sw;
  logic       btn_load;
  logic       btn_clr;
  logic [4:0] x;
  logic [4:0] y;
  logic       ready;
  logic       pair_stb;
  logic [1:0] state;

  int vectors;
  int errors;
  int stb_cnt;
  int stb_bad;
  logic ready_prev;

  operand_entry #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_load(btn_load), .btn_clr(btn_clr),
    .x(x), .y(y), .ready(ready), .pair_stb(pair_stb), .state(state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // pair_stb must be high exactly on the first cycle of each ready interval.
  always @(negedge clk) begin
    if (pair_stb === 1'b1) stb_cnt++;
    if (pair_stb !== (ready & ~ready_prev)) stb_bad++;
    ready_prev = ready;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] ex, input logic [4:0] ey,
                            input logic er, input logic [1:0] es);
    check({tag, ".x"}, {3'b000, x}, {3'b000, ex});
    check({tag, ".y"}, {3'b000, y}, {3'b000, ey});
    check({tag, ".ready"}, {7'd0, ready}, {7'd0, er});
    check({tag, ".state"}, {6'd0, state}, {6'd0, es});
  endtask

  task automatic press(input logic ld, input logic cl, input int n);
    @(negedge clk);
    btn_load = ld;
    btn_clr  = cl;
    repeat (n) @(negedge clk);
    btn_load = 1'b0;
    btn_clr  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    vectors = 0; errors = 0; stb_cnt = 0; stb_bad = 0; ready_prev = 1'b0;
    rst_n = 1'b0; sw = 5'd0; btn_load = 1'b0; btn_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 5'd0, 5'd0, 1'b0, 2'b00);
    check("reset.pair_stb", {7'd0, pair_stb}, 8'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_outs("post_reset_idle", 5'd0, 5'd0, 1'b0, 2'b00);

    // First operand then second operand.
    sw = 5'd9;
    repeat (3) @(negedge clk);
    press(1'b1, 1'b0, 10);
    check_outs("load_x", 5'd9, 5'd0, 1'b0, 2'b01);
    check("load_x.stb_cnt", 8'(stb_cnt), 8'd0);
    sw = 5'd22;
    repeat (3) @(negedge clk);
    press(1'b1, 1'b0, 10);
    check_outs("load_y", 5'd9, 5'd22, 1'b1, 2'b10);
    check("load_y.stb_cnt", 8'(stb_cnt), 8'd1);

    // Bounce shorter than the debounce window must be ignored.
    sw = 5'd17;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      btn_load = 1'b1;
      repeat (2) @(negedge clk);
      btn_load = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check_outs("bounce", 5'd9, 5'd22, 1'b1, 2'b10);
    check("bounce.stb_cnt", 8'(stb_cnt), 8'd1);

    // Load in READY starts a new pair.
    sw = 5'd3;
    repeat (3) @(negedge clk);
    press(1'b1, 1'b0, 10);
    check_outs("ready_reload", 5'd3, 5'd22, 1'b0, 2'b01);

    // Clear and load together in WAIT_Y: clear wins.
    sw = 5'd7;
    repeat (3) @(negedge clk);
    press(1'b1, 1'b1, 10);
    check_outs("clr_prio", 5'd0, 5'd0, 1'b0, 2'b00);
    check("clr_prio.stb_cnt", 8'(stb_cnt), 8'd1);

    // Build a pair, then reset asynchronously mid-cycle with load held.
    sw = 5'd12;
    repeat (3) @(negedge clk);
    press(1'b1, 1'b0, 10);
    sw = 5'd25;
    repeat (3) @(negedge clk);
    press(1'b1, 1'b0, 10);
    check_outs("pair2", 5'd12, 5'd25, 1'b1, 2'b10);
    check("pair2.stb_cnt", 8'(stb_cnt), 8'd2);
    sw = 5'd6;
    btn_load = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 5'd0, 5'd0, 1'b0, 2'b00);
    check("async_rst.pair_stb", {7'd0, pair_stb}, 8'd0);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
    check_outs("held_after_rst", 5'd6, 5'd0, 1'b0, 2'b01);

    // Clear, then measure load latency and single pulse on a long hold.
    press(1'b0, 1'b1, 10);
    check_outs("clear", 5'd0, 5'd0, 1'b0, 2'b00);
    sw = 5'd5;
    repeat (3) @(negedge clk);
    btn_load = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("latency.before", {3'b000, x}, 8'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency.at", {3'b000, x}, 8'd5);
    repeat (43) @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
    check_outs("long_hold", 5'd5, 5'd0, 1'b0, 2'b01);
    check("stb_alignment", 8'(stb_bad), 8'd0);
    check("final.stb_cnt", 8'(stb_cnt), 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL provide parameter DB_CYCLES, default 1000000, stable-cycle count required to accept a button level change (legal range 2..2^20-1).
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port sw  input  5  raw slide-switch operand value, asynchronous to clk.
REQ-005 SHALL provide port btn_load  input  1  raw, bouncing load pushbutton, active-high.
REQ-006 SHALL provide port btn_clr  input  1  raw, bouncing clear pushbutton, active-high.
REQ-007 SHALL provide port x  output  5  captured first operand, registered.
REQ-008 SHALL provide port y  output  5  captured second operand, registered.
REQ-009 SHALL provide port ready  output  1  high while x and y form a complete, valid pair.
REQ-010 SHALL provide port pair_stb  output  1  one-cycle strobe marking a newly completed pair.
REQ-011 SHALL provide port state  output  2  current FSM state encoding, for LED display.

Function
REQ-012 SHALL pass sw, btn_load, btn_clr each through a two-flop synchronizer before any other use.
REQ-013 SHALL debounce each synchronized button independently: 20-bit counter cleared whenever synchronized input equals debounced level, incremented otherwise; debounced level toggles and counter clears on the edge where counter equals DB_CYCLES-1.
REQ-014 SHALL produce load_p (clr_p) high for exactly one cycle, the cycle after the debounced level rises 0->1; falling edges produce no pulse.
REQ-015 SHALL hold the button sustained without generating further pulses.
REQ-016 SHALL implement FSM states WAIT_X=2'b00, WAIT_Y=2'b01, READY=2'b10; 2'b11 unused and SHALL recover to WAIT_X on the next clock.
REQ-017 WAIT_X on load_p: x <= synchronized sw, go WAIT_Y.
REQ-018 WAIT_Y on load_p: y <= synchronized sw, go READY, pair_stb high the following cycle only.
REQ-019 READY on load_p: x <= synchronized sw, y unchanged, ready low, go WAIT_Y (begins a new pair).
REQ-020 clr_p in any state: x <= 0, y <= 0, go WAIT_X; clr_p takes priority over simultaneous load_p.
REQ-021 ready SHALL be high exactly when state == READY; pair_stb SHALL coincide with the first cycle of ready.
REQ-022 x and y SHALL change only on load_p or clr_p edges; no other path modifies them.
REQ-023 Latency from raw btn_load stable-high to x/y update SHALL be 2 (sync) + DB_CYCLES (debounce) + 1 (pulse) cycles, exactly.
REQ-024 Operands SHALL be treated as unsigned 5-bit; no arithmetic performed in this block.

Reset
REQ-025 On rst_n low, immediately and regardless of clk: x=0, y=0, ready=0, pair_stb=0, state=WAIT_X, synchronizers=0, debounced levels=0, counters=0.
REQ-026 Reset asserted mid-debounce or mid-pair SHALL discard the partial operation; a button still held at release SHALL be debounced afresh and produce one load_p.
REQ-027 Outputs SHALL remain at reset values until the first load_p or clr_p after rst_n deasserts.

Verification (DB_CYCLES=4)
REQ-028 sw=5'd9, btn_load high 10 cycles, low; sw=5'd22, btn_load pulse again -> x=9 after first press, y=22, ready=1, pair_stb high exactly one cycle, state=2'b10.
REQ-029 btn_load toggling every 2 cycles for 20 cycles then low -> no load_p, x/y/state unchanged.
REQ-030 In READY (x=9,y=22), press load with sw=5'd3 -> x=3, y=22, ready=0, state=2'b01.
REQ-031 btn_clr and btn_load pressed same cycle in WAIT_Y -> x=0, y=0, state=2'b00, no pair_stb.
REQ-032 rst_n pulsed low asynchronously between clock edges while state=READY -> all outputs 0 before next clk edge; held btn_load after release -> exactly one capture into x.
REQ-033 btn_load held high 50 cycles -> exactly one load_p, measured 2+4+1 cycles after rising edge of raw input.
